// File: rtl/rvfi_ref_compare_shell.sv
// In-order RVFI retirement buffer that steps a reference model one record at a time
// and compares each DUT retirement against the matching reference record, field by field.
module rvfi_ref_compare_shell #(
  parameter int NRET             = 1,
  parameter int XLEN             = 32,
  parameter int DEPTH            = 8,
  parameter int HALT_ON_MISMATCH = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NRET-1:0]           dut_valid_i,
  input  logic [NRET*XLEN-1:0]      dut_pc_i,
  input  logic [NRET*32-1:0]        dut_insn_i,
  input  logic [NRET*5-1:0]         dut_rd_addr_i,
  input  logic [NRET*XLEN-1:0]      dut_rd_wdata_i,
  input  logic [NRET-1:0]           dut_trap_i,
  input  logic                      ref_valid_i,
  output logic                      ref_ready_o,
  input  logic [XLEN-1:0]           ref_pc_i,
  input  logic [31:0]               ref_insn_i,
  input  logic [4:0]                ref_rd_addr_i,
  input  logic [XLEN-1:0]           ref_rd_wdata_i,
  input  logic                      ref_trap_i,
  output logic                      cmp_valid_o,
  output logic                      mismatch_o,
  output logic [4:0]                mismatch_field_o,
  output logic [63:0]               cmp_order_o,
  output logic [31:0]               mismatch_cnt_o,
  output logic [$clog2(DEPTH):0]    fifo_count_o,
  output logic                      overflow_o,
  output logic                      halted_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {EMPTY, ACTIVE, HALTED} state_t;

  logic [XLEN-1:0] r_pcMem    [DEPTH];
  logic [31:0]     r_insnMem  [DEPTH];
  logic [4:0]      r_rdMem    [DEPTH];
  logic [XLEN-1:0] r_wdataMem [DEPTH];
  logic            r_trapMem  [DEPTH];

  state_t          r_state;
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count;
  logic [63:0]     r_order;
  logic            r_cmpValid, r_mismatch, r_overflow, r_halted;
  logic [4:0]      r_field;
  logic [31:0]     r_mismatchCnt;

  logic [CW:0]     w_npush, w_level;
  logic [CW-1:0]   w_countNext;
  logic            w_contig, w_accept, w_drop, w_pendingHalt, w_ready, w_pop;
  logic [4:0]      w_field;
  logic            w_mis;

  always_comb begin
    w_npush = '0;
    for (int i = 0; i < NRET; i++)
      w_npush = w_npush + (CW+1)'(dut_valid_i[i]);
    // Valid lanes form 2^k-1 exactly when adding one clears every set bit.
    w_contig = ((({1'b0, dut_valid_i}) + (NRET+1)'(1)) & {1'b0, dut_valid_i}) == '0;
    w_pendingHalt = (HALT_ON_MISMATCH != 0) && r_cmpValid && r_mismatch;
    w_ready = (r_count != '0) && !r_halted && !w_pendingHalt;
    w_pop   = ref_valid_i && w_ready;
    w_level = {1'b0, r_count} - (CW+1)'(w_pop) + w_npush;
    w_accept = (dut_valid_i != '0) && w_contig && (w_level <= DEPTH_L);
    w_drop   = (dut_valid_i != '0) && !w_accept;
    w_countNext = w_accept ? w_level[CW-1:0] : (r_count - CW'(w_pop));

    w_field = '0;
    w_field[0] = r_pcMem[r_rptr] != ref_pc_i;
    w_field[1] = r_insnMem[r_rptr] != ref_insn_i;
    w_field[2] = r_rdMem[r_rptr] != ref_rd_addr_i;
    w_field[3] = (r_rdMem[r_rptr] != 5'd0) && (ref_rd_addr_i != 5'd0) &&
                 (r_wdataMem[r_rptr] != ref_rd_wdata_i);
    w_field[4] = r_trapMem[r_rptr] != ref_trap_i;
    w_mis = |w_field;
  end

  assign ref_ready_o = w_ready;

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      for (int i = 0; i < NRET; i++) begin
        if (dut_valid_i[i]) begin
          r_pcMem[r_wptr + AW'(i)]    <= dut_pc_i[i*XLEN +: XLEN];
          r_insnMem[r_wptr + AW'(i)]  <= dut_insn_i[i*32 +: 32];
          r_rdMem[r_wptr + AW'(i)]    <= dut_rd_addr_i[i*5 +: 5];
          r_wdataMem[r_wptr + AW'(i)] <= dut_rd_wdata_i[i*XLEN +: XLEN];
          r_trapMem[r_wptr + AW'(i)]  <= dut_trap_i[i];
        end
      end
    end
  end

  // Control state, pointers, counters and registered compare results.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= EMPTY;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_order       <= '0;
      r_cmpValid    <= 1'b0;
      r_mismatch    <= 1'b0;
      r_field       <= '0;
      r_mismatchCnt <= '0;
      r_overflow    <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_cmpValid <= w_pop;
      if (w_accept) r_wptr <= r_wptr + w_npush[AW-1:0];
      if (w_drop)   r_overflow <= 1'b1;
      r_count <= w_countNext;
      if (w_pop) begin
        r_rptr      <= r_rptr + AW'(1);
        r_field     <= w_field;
        r_mismatch  <= w_mis;
        cmp_order_o <= r_order;
        r_order     <= r_order + 64'd1;
        if (w_mis && (r_mismatchCnt != '1))
          r_mismatchCnt <= r_mismatchCnt + 32'd1;
      end
      case (r_state)
        EMPTY:  if (w_countNext != '0) r_state <= ACTIVE;
        ACTIVE: begin
          if (w_pop && w_mis && (HALT_ON_MISMATCH != 0)) begin
            r_state  <= HALTED;
            r_halted <= 1'b1;
          end else if (w_countNext == '0) begin
            r_state <= EMPTY;
          end
        end
        default: r_state <= HALTED;
      endcase
    end
    if (rst_i) cmp_order_o <= '0;
  end

  assign cmp_valid_o      = r_cmpValid;
  assign mismatch_o       = r_mismatch;
  assign mismatch_field_o = r_field;
  assign mismatch_cnt_o   = r_mismatchCnt;
  assign fifo_count_o     = r_count;
  assign overflow_o       = r_overflow;
  assign halted_o         = r_halted;

endmodule
